// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - parametrised HDMI video timing and test-pattern source
//
// Purpose:
//   Generates HSYNC/VSYNC/DE timing (line/frame order: sync, back porch,
//   active, front porch) and one of four test patterns: solid colour,
//   eight colour bars, horizontal gradient, or a per-frame LFSR colour.
//   Every output is registered one cycle after the counter state that
//   decodes it, so all outputs stay mutually aligned.
//
// Optional feature macro: VIDEO_PATTERN_GEN_BORDER_EN
//   When defined, a 1-pixel white border around the active area overrides
//   the selected pattern.
//
// Ports:
//   clk_i          in   pixel clock
//   rst_i          in   asynchronous reset, active-high
//   en_i           in   generator enable (low: counters cleared, outputs idle)
//   pattern_sel_i  in   0 solid, 1 colour bars, 2 gradient, 3 LFSR frame colour
//   solid_color_i  in   {R,G,B} colour for pattern 0
//   hsync_o        out  horizontal sync, active level H_POL
//   vsync_o        out  vertical sync, active level V_POL
//   de_o           out  data enable
//   data_o         out  pixel data {R,G,B}, zero when de_o=0
//   x_o            out  active column, 0 outside active
//   y_o            out  active line, 0 outside active
//   frame_start_o  out  one-cycle pulse for counter state h=0, v=0

module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int COLOR_W  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [1:0]                  pattern_sel_i,
  input  logic [3*COLOR_W-1:0]        solid_color_i,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic                        de_o,
  output logic [3*COLOR_W-1:0]        data_o,
  output logic [$clog2(H_ACTIVE)-1:0] x_o,
  output logic [$clog2(V_ACTIVE)-1:0] y_o,
  output logic                        frame_start_o
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int CW      = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
  localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
  // One extra bit so the end bound stays representable even with a zero front porch.
  localparam logic [HW:0]   H_ACT_END   = (HW+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW:0]   V_ACT_END   = (VW+1)'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [XW-1:0] BAR_W       = XW'(H_ACTIVE / 8);

  localparam logic          HS_ON       = (H_POL != 0);
  localparam logic          VS_ON       = (V_POL != 0);
  localparam logic [31:0]   LFSR_SEED   = 32'hACE12468;
  localparam logic [COLOR_W-1:0] MAX    = {COLOR_W{1'b1}};

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic [1:0]         sh_pat;
  logic [CW-1:0]      sh_col;
  logic [31:0]        lfsr;

  logic               frame_first;
  logic               frame_last;
  logic               h_sync_act;
  logic               v_sync_act;
  logic               h_act;
  logic               v_act;
  logic               act;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [2:0]         bar;
  logic [2:0]         bar_rgb;
  logic [COLOR_W-1:0] grad;
  logic [CW-1:0]      pix;
  logic [CW-1:0]      pix_out;
  logic               lfsr_fb;

  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  assign h_sync_act  = (h_cnt < H_SYNC_END);
  assign v_sync_act  = (v_cnt < V_SYNC_END);
  assign h_act       = (h_cnt >= H_ACT_START) && ({1'b0, h_cnt} < H_ACT_END);
  assign v_act       = (v_cnt >= V_ACT_START) && ({1'b0, v_cnt} < V_ACT_END);
  assign act         = h_act && v_act;

  // Active-relative coordinates; only meaningful while act is high.
  assign x           = XW'(h_cnt - H_ACT_START);
  assign y           = YW'(v_cnt - V_ACT_START);

  assign bar         = 3'(x / BAR_W);
  assign lfsr_fb     = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

  // Gradient wraps every 2^COLOR_W pixels; narrow x is zero-extended.
  generate
    if (XW >= COLOR_W) begin : g_grad_trunc
      assign grad = x[COLOR_W-1:0];
    end else begin : g_grad_ext
      assign grad = {{(COLOR_W-XW){1'b0}}, x};
    end
  endgenerate

  // Bar colour as {R,G,B} on/off flags: white, yellow, cyan, green,
  // magenta, red, blue, black.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    pix = '0;
    case (sh_pat)
      2'd0:    pix = sh_col;
      2'd1:    pix = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
      2'd2:    pix = {grad, grad, grad};
      default: pix = lfsr[CW-1:0];
    endcase
  end

`ifdef VIDEO_PATTERN_GEN_BORDER_EN
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  logic border;
  assign border  = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
  assign pix_out = border ? {MAX, MAX, MAX} : pix;
`else
  assign pix_out = pix;
`endif

  // Timing counters: h wraps each line, v steps on the last pixel of a line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Pattern/colour are captured only at the first cycle of a frame so a
  // mid-frame change never tears the picture. The LFSR steps on the last
  // cycle of the frame, so each frame sees one stable colour.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_pat <= '0;
      sh_col <= '0;
      lfsr   <= LFSR_SEED;
    end else if (!en_i) begin
      lfsr   <= LFSR_SEED;
    end else begin
      if (frame_first) begin
        sh_pat <= pattern_sel_i;
        sh_col <= solid_color_i;
      end
      if (frame_last) begin
        lfsr <= {lfsr[30:0], lfsr_fb};
      end
    end
  end

  // Output register stage: one cycle after the decoding counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_o       <= ~HS_ON;
      vsync_o       <= ~VS_ON;
      de_o          <= 1'b0;
      data_o        <= '0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
    end else if (!en_i) begin
      hsync_o       <= ~HS_ON;
      vsync_o       <= ~VS_ON;
      de_o          <= 1'b0;
      data_o        <= '0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= h_sync_act ? HS_ON : ~HS_ON;
      vsync_o       <= v_sync_act ? VS_ON : ~VS_ON;
      de_o          <= act;
      data_o        <= act ? pix_out : '0;
      x_o           <= act ? x : '0;
      y_o           <= act ? y : '0;
      frame_start_o <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - self-checking bench for video_pattern_gen

module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int CWD = 8;
  localparam int HT = HS + HB + HA + HF;   // 24
  localparam int VT = VS + VB + VA + VF;   // 8
  localparam int FT = HT * VT;             // 192
  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  psel;
  logic [23:0] scol;

  logic        hs, vs, de, fs;
  logic [23:0] data;
  logic [3:0]  x;
  logic [1:0]  y;
  logic        hs_n, vs_n, de_n, fs_n;
  logic [23:0] data_n;
  logic [3:0]  x_n;
  logic [1:0]  y_n;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: position within the frame, captured pattern, LFSR.
  int          pos;
  logic [1:0]  m_pat;
  logic [23:0] m_col;
  logic [31:0] m_lfsr;

  logic        e_hs, e_vs, e_de, e_fs;
  logic [23:0] e_data;
  int          e_x, e_y;

  logic [23:0] bars [8];

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1), .V_POL(1), .COLOR_W(CWD)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .pattern_sel_i(psel), .solid_color_i(scol),
    .hsync_o(hs), .vsync_o(vs), .de_o(de), .data_o(data),
    .x_o(x), .y_o(y), .frame_start_o(fs)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(0), .V_POL(0), .COLOR_W(CWD)
  ) u_dut_n (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .pattern_sel_i(psel), .solid_color_i(scol),
    .hsync_o(hs_n), .vsync_o(vs_n), .de_o(de_n), .data_o(data_n),
    .x_o(x_n), .y_o(y_n), .frame_start_o(fs_n)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (pos=%0d)", tag, obs, exp, pos);
    end
  endtask

  task automatic set_idle();
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0;
    e_data = '0; e_x = 0; e_y = 0;
  endtask

  // Expected outputs after a rising edge, from the inputs seen at that edge.
  task automatic model_edge();
    int h, v, xx;
    if (rst) begin
      pos = 0; m_pat = 2'd0; m_col = '0; m_lfsr = SEED;
      set_idle();
    end else if (!en) begin
      pos = 0; m_lfsr = SEED;
      set_idle();
    end else begin
      h = pos % HT;
      v = pos / HT;
      if (pos == 0) begin
        m_pat = psel;
        m_col = scol;
      end
      e_hs = (h < HS);
      e_vs = (v < VS);
      e_de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
      e_fs = (pos == 0);
      xx   = h - (HS + HB);
      e_x  = e_de ? xx : 0;
      e_y  = e_de ? v - (VS + VB) : 0;
      e_data = '0;
      if (e_de) begin
        case (m_pat)
          2'd0: e_data = m_col;
          2'd1: e_data = bars[xx / (HA / 8)];
          2'd2: e_data = {3{8'(xx % 256)}};
          default: e_data = m_lfsr[23:0];
        endcase
      end
      if (pos == FT - 1) m_lfsr = lfsr_next(m_lfsr);
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic check_outputs();
    chk("hsync",       32'(hs),     32'(e_hs));
    chk("vsync",       32'(vs),     32'(e_vs));
    chk("de",          32'(de),     32'(e_de));
    chk("data",        32'(data),   32'(e_data));
    chk("x",           32'(x),      32'(e_x));
    chk("y",           32'(y),      32'(e_y));
    chk("frame_start", 32'(fs),     32'(e_fs));
    chk("hsync_neg",   32'(hs_n),   32'(!e_hs));
    chk("vsync_neg",   32'(vs_n),   32'(!e_vs));
    chk("de_neg",      32'(de_n),   32'(e_de));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  // Counts pulse widths over exactly one frame period.
  task automatic frame_stats();
    int c_hs, c_vs, c_de, c_fs;
    c_hs = 0; c_vs = 0; c_de = 0; c_fs = 0;
    for (int i = 0; i < FT; i++) begin
      cycle();
      c_hs += int'(hs);
      c_vs += int'(vs);
      c_de += int'(de);
      c_fs += int'(fs);
    end
    chk("hsync_count", 32'(c_hs), 32'(VT * HS));
    chk("vsync_count", 32'(c_vs), 32'(VS * HT));
    chk("de_count",    32'(c_de), 32'(VA * HA));
    chk("fs_count",    32'(c_fs), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    pos = 0; m_pat = 2'd0; m_col = '0; m_lfsr = SEED;
    set_idle();

    rst = 1'b1; en = 1'b0; psel = 2'd0; scol = 24'h0;
    run(3);
    rst = 1'b0;

    // Enable low after reset: idle levels on both polarities.
    run(4);

    // Solid colour, free run with frame statistics.
    en = 1'b1; psel = 2'd0; scol = 24'($urandom);
    frame_stats();
    run(FT);

    psel = 2'd1;
    run(2 * FT);
    psel = 2'd2;
    run(2 * FT);
    psel = 2'd3;
    run(5 * FT);

    // Mid-frame switch solid -> bars: bars only from the next frame.
    psel = 2'd0; scol = 24'($urandom);
    run(FT + 100);
    psel = 2'd1; scol = 24'($urandom);
    run(2 * FT);

    // Random pattern/colour changes at random points in the frame.
    for (int i = 0; i < 8; i++) begin
      psel = 2'($urandom_range(0, 3));
      scol = 24'($urandom);
      run($urandom_range(50, 400));
    end

    // Enable drop mid-frame, then restart.
    psel = 2'd3;
    en = 1'b0;
    run($urandom_range(3, 30));
    en = 1'b1;
    frame_stats();
    run(FT);

    // Asynchronous reset mid-line.
    psel = 2'd2;
    run(FT / 2 + 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hsync",   32'(hs),   32'd0);
    chk("async_rst_vsync",   32'(vs),   32'd0);
    chk("async_rst_de",      32'(de),   32'd0);
    chk("async_rst_data",    32'(data), 32'd0);
    chk("async_rst_fs",      32'(fs),   32'd0);
    chk("async_rst_hsync_n", 32'(hs_n), 32'd1);
    chk("async_rst_vsync_n", 32'(vs_n), 32'd1);
    run(2);
    rst = 1'b0;
    run(2 * FT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
